// File: rtl/pcpi_pkg.sv
// Shared PCPI types and constants for the initiator, its timeout counter and benches.
// The timeout feature is controlled by the PCPI_INITIATOR_TIMEOUT_EN macro.
package pcpi_pkg;

    localparam int XLEN                 = 32;
    localparam int PCPI_DEFAULT_TIMEOUT = 16;

    // RV32M encoding fields, handy for building MUL/DIV test instructions
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/pcpi_initiator_if.sv
// Core request, PCPI bus and core response signals of the PCPI initiator.
// master = initiator (core side), slave = the environment (core pipeline + responders).
interface pcpi_initiator_if #(
    parameter int XLEN = pcpi_pkg::XLEN
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_insn;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;

    logic            pcpi_valid;
    logic [XLEN-1:0] pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_wr;
    logic [XLEN-1:0] pcpi_rd;
    logic            pcpi_wait;
    logic            pcpi_ready;

    logic            resp_valid;
    logic            resp_wr;
    logic [XLEN-1:0] resp_rd;
    logic            resp_illegal;

    modport master (
        input  req_valid, req_insn, req_rs1, req_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output req_ready,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output resp_valid, resp_wr, resp_rd, resp_illegal
    );

    modport slave (
        output req_valid, req_insn, req_rs1, req_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  req_ready,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  resp_valid, resp_wr, resp_rd, resp_illegal
    );

endinterface

// File: rtl/pcpi_timeout_ctr.sv
// Counts consecutive unclaimed BUSY cycles; expire flags the last permitted cycle.
// Only built when PCPI_INITIATOR_TIMEOUT_EN is defined.
`ifdef PCPI_INITIATOR_TIMEOUT_EN
module pcpi_timeout_ctr
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PCPI_DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic inc,
    output logic expire
);
    localparam int             CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;

    // Saturates at LAST so the narrow counter can never wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (enable) begin
            if (clear) begin
                count_reg <= '0;
            end else if (inc && !expire) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign expire = (count_reg == LAST);

endmodule
`endif

// File: rtl/pcpi_initiator.sv
// Core-side PCPI initiator: holds one offloaded instruction on the bus until a responder answers.
// Define PCPI_INITIATOR_TIMEOUT_EN to abort unclaimed instructions as illegal after TIMEOUT_CYCLES.
module pcpi_initiator #(
    parameter int XLEN           = pcpi_pkg::XLEN,
    parameter int TIMEOUT_CYCLES = pcpi_pkg::PCPI_DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    pcpi_initiator_if.master bus
);
    import pcpi_pkg::*;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("pcpi_initiator: TIMEOUT_CYCLES must be within 2..255");
    end

    state_t          state_reg, state_next;
    logic            pcpi_valid_reg, pcpi_valid_next;
    logic [XLEN-1:0] insn_reg, insn_next;
    logic [XLEN-1:0] rs1_reg, rs1_next;
    logic [XLEN-1:0] rs2_reg, rs2_next;
    logic            resp_valid_reg, resp_valid_next;
    logic            resp_wr_reg, resp_wr_next;
    logic [XLEN-1:0] resp_rd_reg, resp_rd_next;
    logic            req_ready;

`ifdef PCPI_INITIATOR_TIMEOUT_EN
    logic resp_illegal_reg, resp_illegal_next;
    logic ctr_clear, ctr_inc, ctr_expire;

    pcpi_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .enable(state_reg != RESP),
        .clear (ctr_clear),
        .inc   (ctr_inc),
        .expire(ctr_expire)
    );
`endif

    assign req_ready = (state_reg == IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            pcpi_valid_reg   <= 1'b0;
            insn_reg         <= '0;
            rs1_reg          <= '0;
            rs2_reg          <= '0;
            resp_valid_reg   <= 1'b0;
            resp_wr_reg      <= 1'b0;
            resp_rd_reg      <= '0;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
            resp_illegal_reg <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            pcpi_valid_reg   <= pcpi_valid_next;
            insn_reg         <= insn_next;
            rs1_reg          <= rs1_next;
            rs2_reg          <= rs2_next;
            resp_valid_reg   <= resp_valid_next;
            resp_wr_reg      <= resp_wr_next;
            resp_rd_reg      <= resp_rd_next;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
            resp_illegal_reg <= resp_illegal_next;
`endif
        end
    end

    // pcpi_valid/resp_valid are registered from the next state so both line up with BUSY/RESP
    always_comb begin
        state_next        = state_reg;
        pcpi_valid_next   = 1'b0;
        insn_next         = insn_reg;
        rs1_next          = rs1_reg;
        rs2_next          = rs2_reg;
        resp_valid_next   = 1'b0;
        resp_wr_next      = resp_wr_reg;
        resp_rd_next      = resp_rd_reg;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
        resp_illegal_next = resp_illegal_reg;
        ctr_clear         = 1'b0;
        ctr_inc           = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.req_valid && req_ready) begin
                    insn_next       = bus.req_insn;
                    rs1_next        = bus.req_rs1;
                    rs2_next        = bus.req_rs2;
                    pcpi_valid_next = 1'b1;
                    state_next      = BUSY;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
                    ctr_clear       = 1'b1;
`endif
                end
            end
            BUSY: begin
                pcpi_valid_next = 1'b1;
                if (bus.pcpi_ready) begin
                    resp_wr_next      = bus.pcpi_wr;
                    resp_rd_next      = bus.pcpi_rd;
                    pcpi_valid_next   = 1'b0;
                    resp_valid_next   = 1'b1;
                    state_next        = RESP;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
                    resp_illegal_next = 1'b0;
                end else if (bus.pcpi_wait) begin
                    ctr_clear         = 1'b1;
                end else if (ctr_expire) begin
                    resp_wr_next      = 1'b0;
                    resp_rd_next      = '0;
                    resp_illegal_next = 1'b1;
                    pcpi_valid_next   = 1'b0;
                    resp_valid_next   = 1'b1;
                    state_next        = RESP;
                end else begin
                    ctr_inc           = 1'b1;
`endif
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.req_ready    = req_ready;
    assign bus.pcpi_valid   = pcpi_valid_reg;
    assign bus.pcpi_insn    = insn_reg;
    assign bus.pcpi_rs1     = rs1_reg;
    assign bus.pcpi_rs2     = rs2_reg;
    assign bus.resp_valid   = resp_valid_reg;
    assign bus.resp_wr      = resp_wr_reg;
    assign bus.resp_rd      = resp_rd_reg;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
    assign bus.resp_illegal = resp_illegal_reg;
`else
    assign bus.resp_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
// Directed bench for pcpi_initiator: vector table of offload transactions plus
// hand-written reset, hang/timeout and back-to-back sequences.
module tb_pcpi_initiator;
    import pcpi_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pcpi_initiator_if #(.XLEN(32)) bus_if ();

    pcpi_initiator #(
        .XLEN          (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          wait_n;     // pcpi_wait high in BUSY cycles 1..wait_n
        int          ready_at;   // BUSY cycle with pcpi_ready (0 = never)
        logic        wr;
        logic [31:0] rd;
        int          exp_cycles; // pcpi_valid high cycles
        logic        exp_illegal;
        logic        exp_wr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_mul(input int rd, input int rs1, input int rs2);
        logic [4:0] r_d, r_1, r_2;
        r_d = 5'(rd);
        r_1 = 5'(rs1);
        r_2 = 5'(rs2);
        return {FUNCT7_MULDIV, r_2, r_1, 3'b000, r_d, OPCODE_OP};
    endfunction

    task automatic wait_idle();
        int bound = 0;
        while (bus_if.req_ready !== 1'b1 && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        check("req_ready before request", 96'(bus_if.req_ready), 96'(1));
    endtask

    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        bus_if.req_valid = 1'b1;
        bus_if.req_insn  = insn;
        bus_if.req_rs1   = rs1;
        bus_if.req_rs2   = rs2;
        @(negedge clk);
        // Scramble the request inputs so any re-latch would be visible
        bus_if.req_valid = 1'b0;
        bus_if.req_insn  = ~insn;
        bus_if.req_rs1   = ~rs1;
        bus_if.req_rs2   = ~rs2;
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int n = 0;
        wait_idle();
        issue(v.insn, v.rs1, v.rs2);
        while (bus_if.pcpi_valid === 1'b1 && n < 2000) begin
            n++;
            check("busy operands", {bus_if.pcpi_insn, bus_if.pcpi_rs1, bus_if.pcpi_rs2},
                  {v.insn, v.rs1, v.rs2});
            check("no resp while busy", 96'(bus_if.resp_valid), 96'(0));
            bus_if.pcpi_wait  = (n <= v.wait_n);
            bus_if.pcpi_ready = (n == v.ready_at);
            bus_if.pcpi_wr    = (n == v.ready_at) ? v.wr : 1'b1;
            bus_if.pcpi_rd    = (n == v.ready_at) ? v.rd : (32'hBAD0_0000 | 32'(n));
            @(negedge clk);
        end
        bus_if.pcpi_wait  = 1'b0;
        bus_if.pcpi_ready = 1'b0;
        bus_if.pcpi_wr    = 1'b1;
        bus_if.pcpi_rd    = 32'h5A5A_A5A5;
        check("pcpi_valid cycles", 96'(n), 96'(v.exp_cycles));
        check("resp_valid pulse", 96'(bus_if.resp_valid), 96'(1));
        check("resp_illegal", 96'(bus_if.resp_illegal), 96'(v.exp_illegal));
        check("resp_wr", 96'(bus_if.resp_wr), 96'(v.exp_wr));
        check("resp_rd", 96'(bus_if.resp_rd), 96'(v.exp_rd));
        $display("vec %0d: insn=%h rs1=%h rs2=%h busy=%0d wr=%b rd=%h illegal=%b",
                 idx, v.insn, v.rs1, v.rs2, n, bus_if.resp_wr, bus_if.resp_rd, bus_if.resp_illegal);
        @(negedge clk);
        check("resp_valid one cycle", 96'(bus_if.resp_valid), 96'(0));
        check("resp_rd held", 96'(bus_if.resp_rd), 96'(v.exp_rd));
        check("pcpi_insn kept", 96'(bus_if.pcpi_insn), 96'(v.insn));
    endtask

    task automatic add_vec(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int wait_n, input int ready_at, input logic wr,
                           input logic [31:0] rd, input int exp_cycles, input logic exp_illegal,
                           input logic exp_wr, input logic [31:0] exp_rd);
        vec_t v;
        v.insn = insn; v.rs1 = rs1; v.rs2 = rs2; v.wait_n = wait_n; v.ready_at = ready_at;
        v.wr = wr; v.rd = rd; v.exp_cycles = exp_cycles; v.exp_illegal = exp_illegal;
        v.exp_wr = exp_wr; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] b_insn[4];
        logic [31:0] b_rs1[4];
        logic [31:0] b_rs2[4];
        bit          saw_resp;
        bit          valid_dropped;

        bus_if.req_valid  = 1'b0;
        bus_if.req_insn   = '0;
        bus_if.req_rs1    = '0;
        bus_if.req_rs2    = '0;
        bus_if.pcpi_wr    = 1'b0;
        bus_if.pcpi_rd    = '0;
        bus_if.pcpi_wait  = 1'b0;
        bus_if.pcpi_ready = 1'b0;

        //       insn          rs1           rs2         wait rdy wr rd            cyc ill ewr erd
        add_vec(32'h02C58533, 32'd3,        32'd5,        0,  3, 1, 32'd15,        3,  0, 1, 32'd15);
`ifdef PCPI_INITIATOR_TIMEOUT_EN
        add_vec(32'h0000000B, 32'd1,        32'd2,        0,  0, 1, 32'd0,         16, 1, 0, 32'd0);
`endif
        add_vec(mk_mul(5,6,7), 32'h1111,    32'h2222,     40, 41, 1, 32'hDEADBEEF, 41, 0, 1, 32'hDEADBEEF);
`ifdef PCPI_INITIATOR_TIMEOUT_EN
        add_vec(32'h0000007B, 32'd9,        32'd9,        10, 0, 1, 32'd0,         26, 1, 0, 32'd0);
`endif
        add_vec(mk_mul(1,2,3), 32'd100,     32'd200,      0, 16, 1, 32'd7,         16, 0, 1, 32'd7);
        add_vec(mk_mul(0,4,8), 32'hFFFFFFFF, 32'h80000000, 0, 1, 0, 32'h12345678, 1,  0, 0, 32'h12345678);
        add_vec(mk_mul(9,9,9), 32'hCAFE,    32'hF00D,     5, 20, 1, 32'hA5A5A5A5,  20, 0, 1, 32'hA5A5A5A5);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset pcpi_valid", 96'(bus_if.pcpi_valid), 96'(0));
        check("reset resp_valid", 96'(bus_if.resp_valid), 96'(0));
        check("reset req_ready", 96'(bus_if.req_ready), 96'(0));
        check("reset latches", {bus_if.pcpi_insn, bus_if.pcpi_rs1, bus_if.pcpi_rs2}, 96'(0));
        check("reset resp", {bus_if.resp_wr, bus_if.resp_illegal, bus_if.resp_rd}, 96'(0));
        reset = 1'b0;
        #1;
        check("req_ready after reset", 96'(bus_if.req_ready), 96'(1));
        @(negedge clk);

        foreach (vecs[i]) run_vector(i, vecs[i]);

`ifndef PCPI_INITIATOR_TIMEOUT_EN
        // Without the timeout an unclaimed instruction must stay on the bus indefinitely
        wait_idle();
        issue(32'h0000000B, 32'd1, 32'd2);
        saw_resp      = 1'b0;
        valid_dropped = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (bus_if.resp_valid !== 1'b0) saw_resp = 1'b1;
            if (bus_if.pcpi_valid !== 1'b1) valid_dropped = 1'b1;
            @(negedge clk);
        end
        check("hang no resp", 96'(saw_resp), 96'(0));
        check("hang pcpi_valid held", 96'(valid_dropped), 96'(0));
        $display("hang: 1000 cycles unclaimed, resp_seen=%b", saw_resp);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif

        // Reset in BUSY cycle 2 discards the request
        wait_idle();
        issue(mk_mul(3,4,5), 32'd11, 32'd13);
        @(negedge clk);
        check("mid-busy pcpi_valid", 96'(bus_if.pcpi_valid), 96'(1));
        bus_if.pcpi_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort pcpi_valid", 96'(bus_if.pcpi_valid), 96'(0));
        check("abort resp_valid", 96'(bus_if.resp_valid), 96'(0));
        check("abort req_ready in reset", 96'(bus_if.req_ready), 96'(0));
        reset = 1'b0;
        #1;
        check("abort req_ready after", 96'(bus_if.req_ready), 96'(1));
        check("abort latches cleared", 96'(bus_if.pcpi_insn), 96'(0));
        saw_resp = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_if.resp_valid !== 1'b0 || bus_if.pcpi_valid !== 1'b0) saw_resp = 1'b1;
        end
        check("abort no later activity", 96'(saw_resp), 96'(0));
        $display("reset mid-busy: activity after reset=%b", saw_resp);

        // Back-to-back with an immediate responder: one acceptance every 3 cycles
        for (int k = 0; k < 4; k++) begin
            b_insn[k] = mk_mul(k + 10, k + 1, k + 2);
            b_rs1[k]  = 32'(k * 7 + 3);
            b_rs2[k]  = 32'(k * 5 + 11);
        end
        wait_idle();
        bus_if.req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            int k;
            k = c / 3;
            case (c % 3)
                0: begin
                    check("b2b req_ready idle", 96'(bus_if.req_ready), 96'(1));
                    check("b2b pcpi_valid idle", 96'(bus_if.pcpi_valid), 96'(0));
                    bus_if.req_insn = b_insn[k];
                    bus_if.req_rs1  = b_rs1[k];
                    bus_if.req_rs2  = b_rs2[k];
                end
                1: begin
                    check("b2b pcpi_valid busy", 96'(bus_if.pcpi_valid), 96'(1));
                    check("b2b req_ready busy", 96'(bus_if.req_ready), 96'(0));
                    check("b2b operands", {bus_if.pcpi_insn, bus_if.pcpi_rs1, bus_if.pcpi_rs2},
                          {b_insn[k], b_rs1[k], b_rs2[k]});
                    bus_if.pcpi_ready = 1'b1;
                    bus_if.pcpi_wr    = 1'b1;
                    bus_if.pcpi_rd    = b_rs1[k] * b_rs2[k];
                end
                default: begin
                    bus_if.pcpi_ready = 1'b0;
                    check("b2b pcpi_valid resp", 96'(bus_if.pcpi_valid), 96'(0));
                    check("b2b req_ready resp", 96'(bus_if.req_ready), 96'(0));
                    check("b2b resp_valid", 96'(bus_if.resp_valid), 96'(1));
                    check("b2b resp_rd", 96'(bus_if.resp_rd), 96'(b_rs1[k] * b_rs2[k]));
                    $display("b2b %0d: rs1=%0d rs2=%0d rd=%0d", k, b_rs1[k], b_rs2[k], bus_if.resp_rd);
                end
            endcase
            @(negedge clk);
        end
        bus_if.req_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcpi_initiator.md
Name: pcpi_initiator

Overview:
- Core-side (initiator) end of the PCPI coprocessor interface. The existing PCPI responders (MUL and the internal/external result mux) sit on the other end.
- Accepts one offload request from the core pipeline and drives pcpi_valid/insn/rs1/rs2 stable until the responder answers.
- Returns the responder's write-back result, or an illegal-instruction indication if no responder claims the instruction within a timeout.

Parameters:
- XLEN, 32, data and instruction width.
- TIMEOUT_CYCLES, 16, number of consecutive unclaimed BUSY cycles before abort; legal range 2..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core offers an instruction.
- req_ready  out  1  block can accept a request.
- req_insn  in  XLEN  instruction word.
- req_rs1  in  XLEN  rs1 operand value.
- req_rs2  in  XLEN  rs2 operand value.
- pcpi_valid  out  1  instruction presented to responders.
- pcpi_insn  out  XLEN  latched instruction.
- pcpi_rs1  out  XLEN  latched rs1.
- pcpi_rs2  out  XLEN  latched rs2.
- pcpi_wr  in  1  responder requests register write-back.
- pcpi_rd  in  XLEN  responder result.
- pcpi_wait  in  1  responder has claimed the instruction, still computing.
- pcpi_ready  in  1  responder result valid this cycle.
- resp_valid  out  1  one-cycle completion pulse to the core.
- resp_wr  out  1  captured pcpi_wr.
- resp_rd  out  XLEN  captured pcpi_rd.
- resp_illegal  out  1  timeout abort; instruction unclaimed.

Behaviour:
- Single clock, synchronous active-high reset; reset has priority over every other event.
- Reset values:
  - state = IDLE.
  - pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2 = 0.
  - resp_valid, resp_wr, resp_rd, resp_illegal = 0.
  - timeout counter = 0.
- FSM states: IDLE, BUSY, RESP.
- req_ready = (state==IDLE) & ~reset. This is combinational, and is the only combinational output.
- IDLE:
  - If req_valid & req_ready, latch insn/rs1/rs2, clear the counter, and go to BUSY.
  - pcpi_valid rises on the cycle after acceptance.
- BUSY:
  - pcpi_valid = 1. insn/rs1/rs2 are held from the latches and must not change.
  - pcpi_ready = 1: capture pcpi_wr and pcpi_rd into resp_wr/resp_rd, set resp_illegal = 0, go to RESP.
  - Else pcpi_wait = 1: clear the counter and stay in BUSY.
  - Else, if counter == TIMEOUT_CYCLES-1: abort with resp_wr = 0, resp_rd = 0, resp_illegal = 1, go to RESP.
  - Else: increment the counter.
  - pcpi_ready has priority over the timeout when both occur in the same cycle.
- RESP:
  - pcpi_valid = 0 and resp_valid = 1 for exactly one cycle, then go to IDLE.
  - resp_wr/resp_rd/resp_illegal hold their values until the next capture.
- Latency:
  - Accept in cycle t, pcpi_valid high from t+1.
  - Ready sampled in cycle r gives resp_valid at r+1.
  - Next acceptance is possible at r+2, so the minimum request period is 3 cycles.
- pcpi_ready, pcpi_wait, pcpi_wr and pcpi_rd are ignored outside BUSY.
- pcpi_insn/rs1/rs2 keep their last value after completion; only reset clears them.
- Reset mid-BUSY or mid-RESP: the next cycle has pcpi_valid = 0, resp_valid = 0 and state IDLE; the in-flight request is discarded.
- No counter wrap: the counter width is clog2(TIMEOUT_CYCLES) and it never exceeds TIMEOUT_CYCLES-1.

Optional Feature:
- Macro PCPI_INITIATOR_TIMEOUT_EN.
- Defined: timeout counter and abort path present, as described above.
- Undefined: no counter logic; BUSY waits indefinitely for pcpi_ready; resp_illegal is tied to 0; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package pcpi_pkg:
  - XLEN.
  - State enum (IDLE/BUSY/RESP).
  - PCPI_DEFAULT_TIMEOUT = 16.
  - OPCODE_OP = 7'b0110011 and FUNCT7_MULDIV = 7'b0000001, for benches.
- Sub-module pcpi_timeout_ctr: inputs clear/inc/enable, output expire. It is compiled only under the macro.

Test Plan:
- Normal completion, MUL: reset, then req insn=0x02C58533 (mul a0,a1,a2), rs1=3, rs2=5; responder raises ready with wr=1, rd=15 in the 3rd BUSY cycle. Required: pcpi_valid high exactly 3 cycles with stable insn/rs1/rs2, then one resp_valid pulse with rd=15, wr=1, illegal=0.
- Timeout (macro on, TIMEOUT_CYCLES=16): wait=0 and ready=0 throughout. Required: pcpi_valid high for 16 cycles, then resp_valid with illegal=1, wr=0, rd=0.
- Wait holds off timeout: wait=1 for 40 cycles, then ready with rd=0xDEADBEEF. Required: no abort, rd=0xDEADBEEF, illegal=0. With the macro off and neither wait nor ready asserted, no response for 1000 cycles.
- Ready on the expiry cycle: ready=1 with rd=7 in BUSY cycle 16, wait=0 throughout. Required: normal completion with rd=7, illegal=0.
- Reset mid-BUSY: assert reset in BUSY cycle 2. Required: next cycle pcpi_valid=0, no resp_valid ever, req_ready=1 after reset drops.
- Back-to-back: req_valid held high with a responder giving immediate ready. Required: accepts every 3 cycles; pcpi_valid pattern 1,0,0 repeating; each resp matches its request.
